game_sprite_anim_display: RTL and testbench

Animated, parametrised sprite renderer for the game's graphics pipeline. Sits between the VGA timing generator and the game's pixel mixer. Holds N_FRAMES bitmaps of arbitrary SPRITE_WIDTH × SPRITE_HEIGHT in a packed parameter and steps through them on a video-frame-synchronous animation timer. Latches sprite position once per video frame so a sprite never tears, supports optional mirroring, and emits registered pixel colour plus sprite bounds.

---
 rtl/game_sprite_anim_display_pkg.sv | 27 ++
 rtl/game_sprite_anim_display_if.sv | 44 ++++
 rtl/game_sprite_anim_display_anim_ctrl.sv | 49 ++++
 rtl/game_sprite_anim_display.sv | 176 +++++++++++++++++
 tb/tb_game_sprite_anim_display.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_sprite_anim_display_pkg.sv
// Shared types and helpers for the animated sprite renderer.
// Colour width comes from GAME_RGB_WIDTH (defaults to 12 when not supplied).
`ifndef GAME_RGB_WIDTH
`define GAME_RGB_WIDTH 12
`endif

package game_sprite_pkg;

  localparam int RGB_WIDTH  = `GAME_RGB_WIDTH;
  localparam int ERGB_WIDTH = 1 + RGB_WIDTH;

  typedef struct packed {
    logic                 e;
    logic [RGB_WIDTH-1:0] rgb;
  } ergb_t;

  // Bit offset of pixel (f,r,c), counted down from the MSB of the packed bitmap.
  function automatic int sprite_pixel_offset(input int f, input int r, input int c,
                                             input int w, input int h);
    return ((f * h + r) * w + c) * ERGB_WIDTH;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_sprite_anim_display_if.sv
// Beam, sprite-control and pixel-output bundle between the video timing
// front end (master) and the sprite renderer (slave).
interface game_sprite_anim_display_if
  import game_sprite_pkg::*;
#(
  parameter int W_X  = 10,
  parameter int W_Y  = 9,
  parameter int FI_W = 2
);

  logic [W_X-1:0]       pixel_x;
  logic [W_Y-1:0]       pixel_y;
  logic                 frame_start;
  logic [W_X-1:0]       sprite_x;
  logic [W_Y-1:0]       sprite_y;
  logic                 anim_en;
  logic                 anim_restart;
  logic                 mirror_x;
  logic                 mirror_y;

  logic                 sprite_within_screen;
  logic [W_X-1:0]       sprite_out_left;
  logic [W_X-1:0]       sprite_out_right;
  logic [W_Y-1:0]       sprite_out_top;
  logic [W_Y-1:0]       sprite_out_bottom;
  logic [FI_W-1:0]      frame_index;
  logic                 rgb_en;
  logic [RGB_WIDTH-1:0] rgb;

  modport master (
    output pixel_x, pixel_y, frame_start, sprite_x, sprite_y,
           anim_en, anim_restart, mirror_x, mirror_y,
    input  sprite_within_screen, sprite_out_left, sprite_out_right,
           sprite_out_top, sprite_out_bottom, frame_index, rgb_en, rgb
  );

  modport slave (
    input  pixel_x, pixel_y, frame_start, sprite_x, sprite_y,
           anim_en, anim_restart, mirror_x, mirror_y,
    output sprite_within_screen, sprite_out_left, sprite_out_right,
           sprite_out_top, sprite_out_bottom, frame_index, rgb_en, rgb
  );

endinterface

// File: rtl/game_sprite_anim_display_anim_ctrl.sv
// Animation timer: counts video frames and steps the bitmap index every
// FRAME_PERIOD enabled frames, wrapping after N_FRAMES.
module game_sprite_anim_ctrl
  import game_sprite_pkg::*;
#(
  parameter int N_FRAMES     = 4,
  parameter int FRAME_PERIOD = 8,
  localparam int FI_W        = idx_width(N_FRAMES),
  localparam int TW          = idx_width(FRAME_PERIOD)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic            anim_en,
  input  logic            anim_restart,
  output logic [FI_W-1:0] frame_index
);

  localparam logic [TW-1:0]   TICK_LAST  = TW'(FRAME_PERIOD - 1);
  localparam logic [FI_W-1:0] FRAME_LAST = FI_W'(N_FRAMES - 1);

  logic [TW-1:0]   tick_cnt_r;
  logic [FI_W-1:0] frame_idx_r;

  // Restart outranks an advance landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_r  <= '0;
      frame_idx_r <= '0;
    end else if (anim_restart) begin
      tick_cnt_r  <= '0;
      frame_idx_r <= '0;
    end else if (frame_start && anim_en) begin
      if (tick_cnt_r == TICK_LAST) begin
        tick_cnt_r  <= '0;
        frame_idx_r <= (frame_idx_r == FRAME_LAST) ? '0 : frame_idx_r + FI_W'(1);
      end else begin
        tick_cnt_r  <= tick_cnt_r + TW'(1);
        frame_idx_r <= frame_idx_r;
      end
    end else begin
      tick_cnt_r  <= tick_cnt_r;
      frame_idx_r <= frame_idx_r;
    end
  end

  assign frame_index = frame_idx_r;

endmodule

// File: rtl/game_sprite_anim_display.sv
// Animated sprite renderer: frame-latched position, bounds, 2-stage pixel
// pipeline. Define GAME_SPRITE_MIRROR_EN to build the mirror_x/mirror_y flip.
module game_sprite_anim_display
  import game_sprite_pkg::*;
#(
  parameter int SPRITE_WIDTH  = 16,
  parameter int SPRITE_HEIGHT = 16,
  parameter int N_FRAMES      = 4,
  parameter int FRAME_PERIOD  = 8,
  parameter logic [N_FRAMES*SPRITE_HEIGHT*SPRITE_WIDTH*ERGB_WIDTH-1:0] SPRITE_PIXELS = '0,
  parameter int screen_width  = 640,
  parameter int screen_height = 480,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height)
) (
  input logic                          clk,
  input logic                          rst,
  game_sprite_anim_display_if.slave    bus
);

  localparam int TOTAL_BITS = N_FRAMES * SPRITE_HEIGHT * SPRITE_WIDTH * ERGB_WIDTH;
  localparam int FI_W       = idx_width(N_FRAMES);
  localparam int CW         = idx_width(SPRITE_WIDTH);
  localparam int RW         = idx_width(SPRITE_HEIGHT);
  localparam int OFF_W      = idx_width(TOTAL_BITS);
  localparam int XW         = w_x + 1;
  localparam int YW         = w_y + 1;

  logic [w_x-1:0]  pos_x_r;
  logic [w_y-1:0]  pos_y_r;
  logic [FI_W-1:0] frame_idx_s;

  logic [XW-1:0]   dx_s, rx_s, ex_s;
  logic [YW-1:0]   dy_s, ry_s, ey_s;
  logic            hit_s, within_s;
  logic [CW-1:0]   col_s;
  logic [RW-1:0]   row_s;

  logic            s1_hit_r;
  logic [FI_W-1:0] s1_frame_r;
  logic [CW-1:0]   s1_col_r;
  logic [RW-1:0]   s1_row_r;

  logic [OFF_W-1:0] off_s;
  ergb_t            pix_s;

  logic                 rgb_en_r;
  logic [RGB_WIDTH-1:0] rgb_r;
  logic                 within_r;
  logic [w_x-1:0]       left_r, right_r;
  logic [w_y-1:0]       top_r, bottom_r;

  game_sprite_anim_ctrl #(
    .N_FRAMES     (N_FRAMES),
    .FRAME_PERIOD (FRAME_PERIOD)
  ) u_anim_ctrl (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (bus.frame_start),
    .anim_en      (bus.anim_en),
    .anim_restart (bus.anim_restart),
    .frame_index  (frame_idx_s)
  );

  // Position shadow: only sampled at frame start so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x_r <= '0;
      pos_y_r <= '0;
    end else if (bus.frame_start) begin
      pos_x_r <= bus.sprite_x;
      pos_y_r <= bus.sprite_y;
    end else begin
      pos_x_r <= pos_x_r;
      pos_y_r <= pos_y_r;
    end
  end

  // A negative (sign-set) difference on either side of an axis means a miss.
  assign dx_s  = {1'b0, bus.pixel_x} - {1'b0, pos_x_r};
  assign rx_s  = {1'b0, pos_x_r} + XW'(SPRITE_WIDTH - 1) - {1'b0, bus.pixel_x};
  assign dy_s  = {1'b0, bus.pixel_y} - {1'b0, pos_y_r};
  assign ry_s  = {1'b0, pos_y_r} + YW'(SPRITE_HEIGHT - 1) - {1'b0, bus.pixel_y};
  assign hit_s = ~dx_s[w_x] & ~rx_s[w_x] & ~dy_s[w_y] & ~ry_s[w_y];

  assign ex_s     = {1'b0, pos_x_r} + XW'(SPRITE_WIDTH - 1);
  assign ey_s     = {1'b0, pos_y_r} + YW'(SPRITE_HEIGHT - 1);
  assign within_s = ~ex_s[w_x] & (ex_s <= XW'(screen_width - 1)) &
                    ~ey_s[w_y] & (ey_s <= YW'(screen_height - 1));

  // Local sprite coordinates, forced to 0 on a miss to keep the lookup in range.
  always_comb begin
    col_s = '0;
    row_s = '0;
    if (hit_s) begin
      col_s = CW'(dx_s);
      row_s = RW'(dy_s);
`ifdef GAME_SPRITE_MIRROR_EN
      if (bus.mirror_x) begin
        col_s = CW'(SPRITE_WIDTH - 1) - CW'(dx_s);
      end else begin
        col_s = CW'(dx_s);
      end
      if (bus.mirror_y) begin
        row_s = RW'(SPRITE_HEIGHT - 1) - RW'(dy_s);
      end else begin
        row_s = RW'(dy_s);
      end
`endif
    end else begin
      col_s = '0;
      row_s = '0;
    end
  end

  // Bounds and on-screen flag registered from the latched position.
  always_ff @(posedge clk) begin
    if (rst) begin
      within_r <= 1'b0;
      left_r   <= '0;
      right_r  <= '0;
      top_r    <= '0;
      bottom_r <= '0;
    end else begin
      within_r <= within_s;
      left_r   <= pos_x_r;
      right_r  <= ex_s[w_x-1:0];
      top_r    <= pos_y_r;
      bottom_r <= ey_s[w_y-1:0];
    end
  end

  // Pipeline stage 1: hit, animation frame and local coordinates.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hit_r   <= 1'b0;
      s1_frame_r <= '0;
      s1_col_r   <= '0;
      s1_row_r   <= '0;
    end else begin
      s1_hit_r   <= hit_s;
      s1_frame_r <= frame_idx_s;
      s1_col_r   <= col_s;
      s1_row_r   <= row_s;
    end
  end

  assign off_s = OFF_W'(TOTAL_BITS - ERGB_WIDTH -
                        sprite_pixel_offset(int'(s1_frame_r), int'(s1_row_r), int'(s1_col_r),
                                            SPRITE_WIDTH, SPRITE_HEIGHT));
  assign pix_s = SPRITE_PIXELS[off_s +: ERGB_WIDTH];

  // Pipeline stage 2: colour lookup; rgb keeps its value while not enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_en_r <= 1'b0;
      rgb_r    <= '0;
    end else if (s1_hit_r && pix_s.e) begin
      rgb_en_r <= 1'b1;
      rgb_r    <= pix_s.rgb;
    end else begin
      rgb_en_r <= 1'b0;
      rgb_r    <= rgb_r;
    end
  end

  assign bus.sprite_within_screen = within_r;
  assign bus.sprite_out_left      = left_r;
  assign bus.sprite_out_right     = right_r;
  assign bus.sprite_out_top       = top_r;
  assign bus.sprite_out_bottom    = bottom_r;
  assign bus.frame_index          = frame_idx_s;
  assign bus.rgb_en               = rgb_en_r;
  assign bus.rgb                  = rgb_r;

endmodule

// File: tb/tb_game_sprite_anim_display.sv
// Randomised bench for game_sprite_anim_display against a cycle-level
// reference model built from integer position/animation arithmetic.
module tb_game_sprite_anim_display;
  import game_sprite_pkg::*;

  localparam int SW    = 16;
  localparam int SH    = 16;
  localparam int NF    = 3;
  localparam int FP    = 2;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int WX    = 10;
  localparam int WY    = 9;
  localparam int FIW   = 2;
  localparam int TOTAL = NF * SH * SW * ERGB_WIDTH;

  function automatic logic pix_e(input int f, input int r, input int c);
    return ((f * 7 + r * 5 + c) % 6) != 0;
  endfunction

  function automatic logic [RGB_WIDTH-1:0] pix_rgb(input int f, input int r, input int c);
    return RGB_WIDTH'(f * 613 + r * 97 + c * 29 + 17);
  endfunction

  function automatic logic [TOTAL-1:0] build_pixels();
    logic [TOTAL-1:0] v;
    int off;
    v = '0;
    for (int f = 0; f < NF; f++) begin
      for (int r = 0; r < SH; r++) begin
        for (int c = 0; c < SW; c++) begin
          off = ((f * SH + r) * SW + c) * ERGB_WIDTH;
          v[TOTAL-1-off -: ERGB_WIDTH] = {pix_e(f, r, c), pix_rgb(f, r, c)};
        end
      end
    end
    return v;
  endfunction

  localparam logic [TOTAL-1:0] PIXELS = build_pixels();

  logic clk;
  logic rst;

  game_sprite_anim_display_if #(.W_X(WX), .W_Y(WY), .FI_W(FIW)) bus ();

  game_sprite_anim_display #(
    .SPRITE_WIDTH  (SW),
    .SPRITE_HEIGHT (SH),
    .N_FRAMES      (NF),
    .FRAME_PERIOD  (FP),
    .SPRITE_PIXELS (PIXELS),
    .screen_width  (SCR_W),
    .screen_height (SCR_H),
    .w_x           (WX),
    .w_y           (WY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // reference model state
  int m_pos_x, m_pos_y, m_n;
  bit pend_en;
  logic [RGB_WIDTH-1:0] pend_rgb;
  bit e_en, e_within;
  logic [RGB_WIDTH-1:0] e_rgb;
  int e_left, e_right, e_top, e_bottom, e_frame;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs sampled at this edge, then compare.
  task automatic tick();
    int px, py, col, row, fr;
    bit hit, nen;
    logic [RGB_WIDTH-1:0] nrgb;
    @(posedge clk);
    if (rst) begin
      m_pos_x = 0; m_pos_y = 0; m_n = 0;
      pend_en = 1'b0; pend_rgb = '0;
      e_en = 1'b0; e_rgb = '0; e_within = 1'b0;
      e_left = 0; e_right = 0; e_top = 0; e_bottom = 0; e_frame = 0;
    end else begin
      px  = int'(bus.pixel_x);
      py  = int'(bus.pixel_y);
      fr  = (m_n / FP) % NF;
      hit = (px >= m_pos_x) && (px <= m_pos_x + SW - 1) &&
            (py >= m_pos_y) && (py <= m_pos_y + SH - 1);
      nen  = 1'b0;
      nrgb = '0;
      if (hit) begin
        col = px - m_pos_x;
        row = py - m_pos_y;
`ifdef GAME_SPRITE_MIRROR_EN
        if (bus.mirror_x) col = SW - 1 - col;
        if (bus.mirror_y) row = SH - 1 - row;
`endif
        nen  = pix_e(fr, row, col);
        nrgb = pix_rgb(fr, row, col);
      end
      e_en = pend_en;
      if (pend_en) e_rgb = pend_rgb;
      pend_en  = nen;
      pend_rgb = nrgb;
      e_left   = m_pos_x;
      e_right  = (m_pos_x + SW - 1) % (1 << WX);
      e_top    = m_pos_y;
      e_bottom = (m_pos_y + SH - 1) % (1 << WY);
      e_within = (m_pos_x + SW - 1 <= SCR_W - 1) && (m_pos_y + SH - 1 <= SCR_H - 1);
      if (bus.anim_restart) m_n = 0;
      else if (bus.frame_start && bus.anim_en) m_n++;
      e_frame = (m_n / FP) % NF;
      if (bus.frame_start) begin
        m_pos_x = int'(bus.sprite_x);
        m_pos_y = int'(bus.sprite_y);
      end
    end
    #1;
    check_eq("rgb_en", bus.rgb_en, e_en);
    check_eq("rgb", bus.rgb, e_rgb);
    check_eq("within", bus.sprite_within_screen, e_within);
    check_eq("left", bus.sprite_out_left, e_left);
    check_eq("right", bus.sprite_out_right, e_right);
    check_eq("top", bus.sprite_out_top, e_top);
    check_eq("bottom", bus.sprite_out_bottom, e_bottom);
    check_eq("frame_index", bus.frame_index, e_frame);
  endtask

  task automatic pulse(input int sx, input int sy);
    bus.sprite_x    = WX'(sx);
    bus.sprite_y    = WY'(sy);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int exp_seq[7];
    int cnt, exp_cnt, px;
    exp_seq = '{0, 0, 1, 1, 2, 2, 0};
    checks = 0;
    failures = 0;

    rst = 1'b1;
    bus.pixel_x = '0; bus.pixel_y = '0; bus.frame_start = 1'b0;
    bus.sprite_x = '0; bus.sprite_y = '0; bus.anim_en = 1'b0;
    bus.anim_restart = 1'b0; bus.mirror_x = 1'b0; bus.mirror_y = 1'b0;
    tick();
    tick();
    check_eq("rst_rgb_en", bus.rgb_en, 32'd0);
    check_eq("rst_frame", bus.frame_index, 32'd0);
    rst = 1'b0;
    tick();

    // latch position, check spec bounds
    pulse(100, 50);
    check_eq("bnd_left", bus.sprite_out_left, 32'd100);
    check_eq("bnd_right", bus.sprite_out_right, 32'd115);
    check_eq("bnd_top", bus.sprite_out_top, 32'd50);
    check_eq("bnd_bottom", bus.sprite_out_bottom, 32'd65);
    check_eq("bnd_within", bus.sprite_within_screen, 32'd1);

    // sweep across row 0 of frame 0
    exp_cnt = 0;
    for (int c = 0; c < SW; c++) exp_cnt += int'(pix_e(0, 0, c));
    cnt = 0;
    bus.pixel_y = WY'(50);
    for (int x = 98; x < 120; x++) begin
      bus.pixel_x = WX'(x);
      tick();
      if (bus.rgb_en) cnt++;
    end
    check_eq("sweep_count", cnt, exp_cnt);

    // mirror at column 0
    bus.mirror_x = 1'b1;
    bus.pixel_x  = WX'(100);
    tick();
    tick();
`ifdef GAME_SPRITE_MIRROR_EN
    check_eq("mirror_en", bus.rgb_en, 32'(pix_e(0, 0, 15)));
    check_eq("mirror_rgb", bus.rgb, 32'(pix_rgb(0, 0, 15)));
`else
    check_eq("mirror_en", bus.rgb_en, 32'(pix_e(0, 0, 0)));
`endif
    bus.mirror_x = 1'b0;

    // off-screen sprite; later sprite_x change without frame_start
    pulse(630, 50);
    check_eq("off_within", bus.sprite_within_screen, 32'd0);
    check_eq("off_left", bus.sprite_out_left, 32'd630);
    bus.sprite_x = WX'(200);
    tick(); tick(); tick();
    check_eq("hold_left", bus.sprite_out_left, 32'd630);

    // animation sequence with wrap
    bus.anim_restart = 1'b1;
    tick();
    bus.anim_restart = 1'b0;
    bus.anim_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check_eq("anim_seq", bus.frame_index, exp_seq[i]);
      pulse(100, 50);
    end
    pulse(100, 50);
    pulse(100, 50);
    check_eq("anim_pre_hold", bus.frame_index, 32'd1);
    bus.anim_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulse(100, 50);
      check_eq("anim_hold", bus.frame_index, 32'd1);
    end
    bus.anim_en = 1'b1;
    bus.anim_restart = 1'b1;
    pulse(100, 50);
    bus.anim_restart = 1'b0;
    check_eq("anim_restart", bus.frame_index, 32'd0);
    pulse(100, 50);
    check_eq("anim_after_restart", bus.frame_index, 32'd0);
    pulse(100, 50);
    check_eq("anim_after_restart2", bus.frame_index, 32'd1);

    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      rst              = ($urandom_range(0, 499) == 0);
      bus.frame_start  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) bus.sprite_x = WX'($urandom_range(0, 1023));
      else                           bus.sprite_x = WX'($urandom_range(0, 650));
      bus.sprite_y     = WY'($urandom_range(0, 511));
      bus.anim_en      = ($urandom_range(0, 3) != 0);
      bus.anim_restart = ($urandom_range(0, 49) == 0);
      bus.mirror_x     = $urandom_range(0, 1) == 1;
      bus.mirror_y     = $urandom_range(0, 1) == 1;
      px = m_pos_x + int'($urandom_range(0, SW + 3)) - 2;
      bus.pixel_x = WX'(px & 1023);
      px = m_pos_y + int'($urandom_range(0, SH + 3)) - 2;
      bus.pixel_y = WY'(px & 511);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
